// File: rtl/mem_pkg.sv
// Shared constants and encodings for the memory arbiter slice.
package mem_pkg;

  localparam int AW      = 9;
  localparam int DW      = 16;
  localparam int LO_TOP  = 30;
  localparam int HI_BASE = 497;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_BUSY  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  // Unmapped hole between the low and high regions.
  function automatic logic in_hole(logic [AW-1:0] a);
    return (int'(a) > LO_TOP) && (int'(a) < HI_BASE);
  endfunction

endpackage

// File: rtl/mem_prio_sel.sv
// Data-first grant selection with an anti-starvation streak counter for fetch.
module mem_prio_sel #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic grant_en,
  input  logic i_req,
  input  logic d_req,
  output logic grant_vld,
  output logic grant_d
);

  localparam logic [1:0] LIM = 2'(STARVE_LIMIT);

  logic [1:0] streak;

  assign grant_vld = grant_en & (i_req | d_req);
  assign grant_d   = d_req & ~(i_req & (streak == LIM));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      streak <= '0;
    end else if (grant_vld) begin
      if (!grant_d)
        streak <= '0;
      else if (i_req && streak != LIM)
        streak <= streak + 2'd1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-client arbiter in front of the 512x16 multi-cycle memory; one transaction in flight.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  output logic          i_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  output logic          mem_start,
  output logic          mem_rwn,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata
);

  state_t          state;
  owner_t          own;
  logic            grant_vld, grant_d;
  logic [AW-1:0]   sel_addr;
  logic            sel_we;
  logic [DW-1:0]   sel_wdata;

  mem_prio_sel #(.STARVE_LIMIT(STARVE_LIMIT)) u_sel (
    .clk       (clk),
    .reset     (reset),
    .grant_en  (state == S_IDLE && mem_ready),
    .i_req     (i_req),
    .d_req     (d_req),
    .grant_vld (grant_vld),
    .grant_d   (grant_d)
  );

  // Fetch port is read-only: its write enable and data are forced off.
  assign sel_addr  = grant_d ? d_addr : i_addr;
  assign sel_we    = grant_d & d_we;
  assign sel_wdata = grant_d ? d_wdata : '0;

  // mem_addr/mem_rwn/mem_wdata double as the transaction latches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      own       <= OWN_I;
      i_ack     <= 1'b0;
      i_rvalid  <= 1'b0;
      i_rdata   <= '0;
      i_err     <= 1'b0;
      d_ack     <= 1'b0;
      d_rvalid  <= 1'b0;
      d_rdata   <= '0;
      d_err     <= 1'b0;
      mem_start <= 1'b0;
      mem_rwn   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      i_ack    <= 1'b0;
      d_ack    <= 1'b0;
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (grant_vld) begin
            own       <= grant_d ? OWN_D : OWN_I;
            i_ack     <= ~grant_d;
            d_ack     <= grant_d;
            mem_addr  <= sel_addr;
            mem_rwn   <= ~sel_we;
            mem_wdata <= sel_wdata;
            mem_start <= ~in_hole(sel_addr);
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          mem_start <= 1'b0;
          state     <= in_hole(mem_addr) ? S_FAULT : S_BUSY;
        end
        S_BUSY: begin
          if (mem_ready) begin
            if (own == OWN_D) begin
              d_rvalid <= 1'b1;
              d_rdata  <= mem_rwn ? mem_rdata : '0;
              d_err    <= 1'b0;
            end else begin
              i_rvalid <= 1'b1;
              i_rdata  <= mem_rdata;
              i_err    <= 1'b0;
            end
            state <= S_IDLE;
          end
        end
        S_FAULT: begin
          if (own == OWN_D) begin
            d_rvalid <= 1'b1;
            d_rdata  <= '0;
            d_err    <= 1'b1;
          end else begin
            i_rvalid <= 1'b1;
            i_rdata  <= '0;
            i_err    <= 1'b1;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural multi-cycle memory model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req = 1'b0;
  logic [8:0]  i_addr = '0;
  logic        i_ack, i_rvalid, i_err;
  logic [15:0] i_rdata;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [8:0]  d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic        d_ack, d_rvalid, d_err;
  logic [15:0] d_rdata;
  logic        mem_start, mem_rwn;
  logic [8:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ready = 1'b1;
  logic [15:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_start(mem_start), .mem_rwn(mem_rwn), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: busy for addr[1:0]+1 edges after the start edge.
  logic [15:0] mem [512];
  logic [1:0]  m_cnt = '0;
  logic [8:0]  m_a = '0;
  logic        m_rwn = 1'b1;
  logic [15:0] m_wd = '0;

  always @(posedge clk) begin
    if (mem_ready && mem_start) begin
      mem_ready <= 1'b0;
      m_cnt     <= mem_addr[1:0];
      m_a       <= mem_addr;
      m_rwn     <= mem_rwn;
      m_wd      <= mem_wdata;
    end else if (!mem_ready) begin
      if (m_cnt == 2'd0) begin
        mem_ready <= 1'b1;
        if (m_rwn) mem_rdata <= mem[m_a];
        else       mem[m_a]  <= m_wd;
      end else begin
        m_cnt <= m_cnt - 2'd1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // One transaction: ack on the first edge, then latency, data, err and start count.
  task automatic xact(input string tag, input bit is_d, input bit we, input logic [8:0] a,
                      input logic [15:0] wd, input logic [15:0] exp_rd, input bit exp_err);
    int lat, starts, exp_lat;
    logic rv, ack;
    exp_lat = exp_err ? 2 : int'(a[1:0]) + 3;
    @(negedge clk);
    if (is_d) begin d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; end
    else begin i_req = 1'b1; i_addr = a; end
    @(posedge clk); #1;
    ack = is_d ? d_ack : i_ack;
    chk({tag, "_ack"}, ack, 1);
    d_req = 1'b0; i_req = 1'b0;
    starts = int'(mem_start);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (mem_start) starts++;
      rv = is_d ? d_rvalid : i_rvalid;
      if (rv) begin lat = n; break; end
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_rdata"}, is_d ? d_rdata : i_rdata, exp_rd);
    chk({tag, "_err"}, is_d ? d_err : i_err, exp_err);
    chk({tag, "_starts"}, starts, exp_err ? 0 : 1);
    @(posedge clk); #1;
    rv = is_d ? d_rvalid : i_rvalid;
    chk({tag, "_pulse"}, rv, 0);
  endtask

  logic [7:0] got_g;
  int ng, rv_cnt;

  initial begin
    for (int j = 0; j < 512; j++) mem[j] = 16'h0;
    mem[1] = 16'h8C00; mem[3] = 16'h0333; mem[4] = 16'h01B0;
    mem[5] = 16'hAD00; mem[30] = 16'h3030; mem[497] = 16'h5A5A;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_i", {i_ack, i_rvalid, i_err, i_rdata}, 0);
    chk("rst_d", {d_ack, d_rvalid, d_err, d_rdata}, 0);
    chk("rst_mem", {mem_start, mem_rwn, mem_addr, mem_wdata}, 0);
    @(negedge clk); reset = 1'b0;

    // Both requests held: data wins three times, then fetch.
    @(negedge clk);
    i_req = 1'b1; i_addr = 9'd200; d_req = 1'b1; d_we = 1'b0; d_addr = 9'd300;
    got_g = '0; ng = 0;
    for (int c = 0; c < 200 && ng < 8; c++) begin
      @(posedge clk); #1;
      if (d_ack) begin got_g[ng] = 1'b1; ng++; end
      else if (i_ack) begin got_g[ng] = 1'b0; ng++; end
    end
    i_req = 1'b0; d_req = 1'b0;
    chk("grant_n", ng, 8);
    chk("grant_order", got_g, 8'b0111_0111);
    repeat (6) @(posedge clk);

    xact("rd5",   1, 0, 9'd5,   16'h0,    16'hAD00, 0);
    xact("wr26",  1, 1, 9'd26,  16'h1234, 16'h0000, 0);
    xact("rd26",  1, 0, 9'd26,  16'h0,    16'h1234, 0);
    chk("mem26", mem[26], 16'h1234);
    xact("if100", 0, 0, 9'd100, 16'h0,    16'h0000, 1);
    xact("if497", 0, 0, 9'd497, 16'h0,    16'h5A5A, 0);
    xact("d31",   1, 0, 9'd31,  16'h0,    16'h0000, 1);
    xact("d496",  1, 1, 9'd496, 16'hFFFF, 16'h0000, 1);
    chk("mem496", mem[496], 16'h0000);
    xact("d30",   1, 0, 9'd30,  16'h0,    16'h3030, 0);
    xact("if1",   0, 0, 9'd1,   16'h0,    16'h8C00, 0);
    xact("if4",   0, 0, 9'd4,   16'h0,    16'h01B0, 0);
    chk("d_hold", d_rdata, 16'h3030);

    // Reset while the memory is busy on addr 3.
    @(negedge clk); d_req = 1'b1; d_we = 1'b0; d_addr = 9'd3;
    @(posedge clk); #1; d_req = 1'b0;
    chk("rb_ack", d_ack, 1);
    repeat (2) @(posedge clk);
    #1; reset = 1'b1; #1;
    chk("rb_i", {i_ack, i_rvalid, i_err, i_rdata}, 0);
    chk("rb_d", {d_ack, d_rvalid, d_err, d_rdata}, 0);
    chk("rb_mem", {mem_start, mem_rwn, mem_addr, mem_wdata}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rv_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (d_rvalid || i_rvalid) rv_cnt++;
    end
    chk("rb_no_rvalid", rv_cnt, 0);
    xact("rd3", 1, 0, 9'd3, 16'h0, 16'h0333, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
